// File: rtl/div_pkg.sv
// Shared encodings for the RV32M sequential divider: operation codes and FSM states.
package div_pkg;

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SPECIAL = 3'd1,
        LOAD    = 3'd2,
        ITER    = 3'd3,
        FIX     = 3'd4
    } state_t;

endpackage

// File: rtl/div_step.sv
// One restoring division step: shift {rem,quo} left by one and try subtracting the divisor.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_nxt,
    output logic [WIDTH-1:0] quo_nxt
);

    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] trial;

    // Extra top bit on trial carries the borrow; rem < divisor keeps shifted within WIDTH+1 bits.
    always_comb begin
        shifted = {rem, quo[WIDTH-1]};
        trial   = {1'b0, shifted} - {2'b00, divisor};
        if (!trial[WIDTH+1]) begin
            rem_nxt = trial[WIDTH-1:0];
            quo_nxt = {quo[WIDTH-2:0], 1'b1};
        end else begin
            rem_nxt = shifted[WIDTH-1:0];
            quo_nxt = {quo[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/divider_seq.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU, one quotient bit per clock.
//   state   | meaning
//   IDLE    | waiting for start_i; operands latched on accept
//   SPECIAL | divide-by-zero or signed overflow, result produced directly
//   LOAD    | take operand magnitudes, record result signs, arm counter
//   ITER    | one restoring step per cycle, WIDTH cycles
//   FIX     | apply result signs, select quotient/remainder, pulse done_o
module divider_seq
    import div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] op_A_i,
    input  logic [WIDTH-1:0] op_B_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    state_t           state;
    logic [1:0]       op_q;
    logic             sgn_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic [WIDTH-1:0] quo_q, rem_q, dvs_q;
    logic [CW-1:0]    cnt_q;
    logic             neg_q, neg_r;

    logic             is_special;
    logic [WIDTH-1:0] rem_nxt, quo_nxt;
    logic [WIDTH-1:0] quo_fix, rem_fix, spec_quo, spec_rem;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem     (rem_q),
        .quo     (quo_q),
        .divisor (dvs_q),
        .rem_nxt (rem_nxt),
        .quo_nxt (quo_nxt)
    );

    always_comb begin
        is_special = (op_B_i == '0) ||
                     (!op_i[0] && op_A_i == MIN_NEG && op_B_i == '1);
        // Negating a zero remainder yields zero, so no explicit guard is needed.
        quo_fix  = neg_q ? (~quo_q + 1'b1) : quo_q;
        rem_fix  = neg_r ? (~rem_q + 1'b1) : rem_q;
        spec_quo = (b_q == '0) ? '1  : a_q;
        spec_rem = (b_q == '0) ? a_q : '0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= IDLE;
            op_q     <= '0;
            sgn_q    <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            quo_q    <= '0;
            rem_q    <= '0;
            dvs_q    <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            busy_o   <= 1'b0;
            done_o   <= 1'b0;
            result_o <= '0;
        end else begin
            done_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_i) begin
                        op_q   <= op_i;
                        sgn_q  <= ~op_i[0];
                        a_q    <= op_A_i;
                        b_q    <= op_B_i;
                        busy_o <= 1'b1;
                        state  <= is_special ? SPECIAL : LOAD;
                    end
                end
                SPECIAL: begin
                    result_o <= op_q[1] ? spec_rem : spec_quo;
                    done_o   <= 1'b1;
                    busy_o   <= 1'b0;
                    state    <= IDLE;
                end
                LOAD: begin
                    quo_q <= (sgn_q && a_q[WIDTH-1]) ? (~a_q + 1'b1) : a_q;
                    dvs_q <= (sgn_q && b_q[WIDTH-1]) ? (~b_q + 1'b1) : b_q;
                    neg_q <= sgn_q && (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
                    neg_r <= sgn_q && a_q[WIDTH-1];
                    rem_q <= '0;
                    cnt_q <= CW'(WIDTH - 1);
                    state <= ITER;
                end
                ITER: begin
                    rem_q <= rem_nxt;
                    quo_q <= quo_nxt;
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == '0) state <= FIX;
                end
                FIX: begin
                    result_o <= op_q[1] ? rem_fix : quo_fix;
                    done_o   <= 1'b1;
                    busy_o   <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
